// File: rtl/gerador_sequencia.sv
// Word FIFO feeding an MSB-first serializer with optional inter-word gap.
// Optional even-parity bit per word is enabled by defining GERADOR_PARIDADE_EN.
module gerador_sequencia #(
  parameter int PROFUNDIDADE = 4,
  parameter int GAP          = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       carregar,
  input  logic [7:0] palavra,
  output logic       pronto,
  output logic       bit_out,
  output logic       bit_valido,
  output logic       start_out,
  output logic       ocupado
);

  localparam int AW = $clog2(PROFUNDIDADE);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(PROFUNDIDADE);
  localparam logic [3:0]    GAP_M1  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

`ifdef GERADOR_PARIDADE_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP_S} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP_S} state_t;
`endif

  logic [7:0]    mem [PROFUNDIDADE];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  state_t        state;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic [3:0]    gap_cnt;
`ifdef GERADOR_PARIDADE_EN
  logic          parity;
`endif

  logic       push, pop, word_end, launch, fifo_empty, idle_next;
  logic [7:0] head;

  assign pronto     = count < DEPTH_C;
  assign push       = carregar && pronto;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];

`ifdef GERADOR_PARIDADE_EN
  assign word_end = (state == PAR);
`else
  assign word_end = (state == SHIFT) && (bit_cnt == 3'd0);
`endif

  // An edge where the engine is free to start a word; it pops if anything is queued.
  assign launch     = (state == IDLE) || (word_end && (GAP == 0)) ||
                      ((state == GAP_S) && (gap_cnt == 4'd0));
  assign pop        = launch && !fifo_empty;
  assign idle_next  = launch && fifo_empty;
  assign count_next = count + CW'(push) - CW'(pop);

  // NOTE: the word storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= palavra;
  end

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      bit_out    <= 1'b0;
      bit_valido <= 1'b0;
      start_out  <= 1'b0;
      ocupado    <= 1'b0;
`ifdef GERADOR_PARIDADE_EN
      parity     <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      ocupado <= (count_next != '0) || !idle_next;

      if (pop) begin
        // shift_reg holds the bits still to be sent, already aligned to bit 7.
        state      <= SHIFT;
        shift_reg  <= {head[6:0], 1'b0};
        bit_cnt    <= 3'd7;
        bit_out    <= head[7];
        bit_valido <= 1'b1;
        start_out  <= (state == IDLE);
`ifdef GERADOR_PARIDADE_EN
        parity     <= ^head;
`endif
      end else if (idle_next) begin
        state      <= IDLE;
        bit_out    <= 1'b0;
        bit_valido <= 1'b0;
        start_out  <= 1'b0;
      end else begin
        start_out <= 1'b0;
        case (state)
          SHIFT: begin
            if (bit_cnt != 3'd0) begin
              shift_reg  <= shift_reg << 1;
              bit_cnt    <= bit_cnt - 3'd1;
              bit_out    <= shift_reg[7];
              bit_valido <= 1'b1;
            end else begin
`ifdef GERADOR_PARIDADE_EN
              state      <= PAR;
              bit_out    <= parity;
              bit_valido <= 1'b1;
`else
              state      <= GAP_S;
              gap_cnt    <= GAP_M1;
              bit_out    <= 1'b0;
              bit_valido <= 1'b0;
`endif
            end
          end
`ifdef GERADOR_PARIDADE_EN
          PAR: begin
            state      <= GAP_S;
            gap_cnt    <= GAP_M1;
            bit_out    <= 1'b0;
            bit_valido <= 1'b0;
          end
`endif
          GAP_S: begin
            gap_cnt <= gap_cnt - 4'd1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gerador_sequencia.sv
// Scoreboard bench: two instances (GAP=0/depth 4 and GAP=3/depth 2) driven by shared
// stimulus, checked against a slot-based reference model of the serializer.
module tb_gerador_sequencia;

  localparam int P0 = 4, G0 = 0, P1 = 2, G1 = 3;
`ifdef GERADOR_PARIDADE_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       carregar = 1'b0;
  logic [7:0] palavra = 8'h00;
  logic [1:0] pronto, bit_out, bit_valido, start_out, ocupado;

  gerador_sequencia #(.PROFUNDIDADE(P0), .GAP(G0)) dut0 (
    .clk(clk), .rst_n(rst_n), .carregar(carregar), .palavra(palavra),
    .pronto(pronto[0]), .bit_out(bit_out[0]), .bit_valido(bit_valido[0]),
    .start_out(start_out[0]), .ocupado(ocupado[0])
  );

  gerador_sequencia #(.PROFUNDIDADE(P1), .GAP(G1)) dut1 (
    .clk(clk), .rst_n(rst_n), .carregar(carregar), .palavra(palavra),
    .pronto(pronto[1]), .bit_out(bit_out[1]), .bit_valido(bit_valido[1]),
    .start_out(start_out[1]), .ocupado(ocupado[1])
  );

  always #5 clk = ~clk;

  typedef struct packed {logic b; logic s;} exp_t;
  exp_t eq0[$];
  exp_t eq1[$];

  int total = 0;
  int bad   = 0;
  int depth_v[2] = '{P0, P1};
  int gap_v[2]   = '{G0, G1};
  logic [7:0] mf[2][8];
  int mc[2];
  int rem[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input int k, input logic [7:0] w, input logic st);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.b = w[7-i];
      e.s = st && (i == 0);
      if (k == 0) eq0.push_back(e); else eq1.push_back(e);
    end
`ifdef GERADOR_PARIDADE_EN
    e.b = ($countones(w) % 2) == 1;
    e.s = 1'b0;
    if (k == 0) eq0.push_back(e); else eq1.push_back(e);
`endif
  endtask

  // Each word owns FRAME+GAP cycles; a new word starts when the engine is free.
  task automatic model_edge(input int k, input logic c, input logic [7:0] w);
    int slot;
    logic acc;
    logic st;
    logic [7:0] pw;
    slot = FRAME + gap_v[k];
    acc  = c && (mc[k] < depth_v[k]);
    if (rem[k] <= 1) begin
      st = (rem[k] == 0);
      if (mc[k] > 0) begin
        pw = mf[k][0];
        for (int i = 0; i < 7; i++) mf[k][i] = mf[k][i+1];
        mc[k]--;
        rem[k] = slot;
        push_frame(k, pw, st);
      end else begin
        rem[k] = 0;
      end
    end else begin
      rem[k]--;
    end
    if (acc) begin
      mf[k][mc[k]] = w;
      mc[k]++;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mc[k]  = 0;
      rem[k] = 0;
    end
    eq0.delete();
    eq1.delete();
  endtask

  task automatic step(input logic c, input logic [7:0] w);
    int slot;
    carregar = c;
    palavra  = w;
    @(posedge clk);
    model_edge(0, c, w);
    model_edge(1, c, w);
    #1;
    for (int k = 0; k < 2; k++) begin
      slot = FRAME + gap_v[k];
      check($sformatf("pronto%0d", k), 32'(pronto[k]), 32'(mc[k] < depth_v[k]));
      check($sformatf("ocupado%0d", k), 32'(ocupado[k]), 32'((mc[k] > 0) || (rem[k] > 0)));
      check($sformatf("valido%0d", k), 32'(bit_valido[k]),
            32'((rem[k] > 0) && ((slot - rem[k]) < FRAME)));
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_pronto%0d", tag, k), 32'(pronto[k]), 32'd1);
      check($sformatf("%s_bit%0d", tag, k), 32'(bit_out[k]), 32'd0);
      check($sformatf("%s_valido%0d", tag, k), 32'(bit_valido[k]), 32'd0);
      check($sformatf("%s_start%0d", tag, k), 32'(start_out[k]), 32'd0);
      check($sformatf("%s_ocupado%0d", tag, k), 32'(ocupado[k]), 32'd0);
    end
  endtask

  // Monitor: pops the scoreboard whenever an instance presents a valid bit.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   n;
    for (int k = 0; k < 2; k++) begin
      if (bit_valido[k]) begin
        n = (k == 0) ? eq0.size() : eq1.size();
        if (n == 0) begin
          check($sformatf("extra_bit%0d", k), 32'(bit_valido[k]), 32'd0);
        end else begin
          if (k == 0) e = eq0.pop_front(); else e = eq1.pop_front();
          check($sformatf("bit%0d", k), 32'(bit_out[k]), 32'(e.b));
          check($sformatf("start%0d", k), 32'(start_out[k]), 32'(e.s));
        end
      end else begin
        check($sformatf("quiet_bit%0d", k), 32'(bit_out[k]), 32'd0);
        check($sformatf("quiet_start%0d", k), 32'(start_out[k]), 32'd0);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    step(1'b1, 8'hA5);
    repeat (14) step(1'b0, 8'h00);

    step(1'b1, 8'h0F);
    step(1'b1, 8'hF0);
    repeat (30) step(1'b0, 8'h00);

    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h31 + 8'(i * 17)));
    repeat (80) step(1'b0, 8'h00);

    step(1'b1, 8'h81);
    step(1'b1, 8'h81);
    repeat (30) step(1'b0, 8'h00);

    step(1'b1, 8'h07);
    repeat (15) step(1'b0, 8'h00);
    step(1'b1, 8'h03);
    repeat (15) step(1'b0, 8'h00);

    repeat (400) step($urandom_range(0, 2) == 0, 8'($urandom));
    repeat (100) step(1'b0, 8'h00);

    // Reset in the middle of 0xC3 with two more words waiting.
    step(1'b1, 8'hC3);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) step(1'b0, 8'h00);

    // Word offered on the very first edge after release must be taken.
    #2 rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 8'h3C);
    repeat (30) step(1'b0, 8'h00);

    check("drain0", 32'(eq0.size()), 32'd0);
    check("drain1", 32'(eq1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
